dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that sits directly upstream of the DDS core and drives its 12-bit `freq_ctrl` input. From a start/stop/step/dwell program it steps the tuning word linearly. It supports single-shot, repeating sawtooth and triangle (up/down) sweeps, with a start/busy/done handshake toward the test controller. This produces chirps on the DDS ramp and square outputs without software pacing.

---
 rtl/dds_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// ============================================================================
// Module   : dds_sweep_ctrl
// Brief    : Linear frequency-sweep sequencer driving the 12-bit DDS tuning
//            word (single / repeat / triangle) with start/busy/done handshake.
//            Optional macro DDS_SWEEP_TRIANGLE_EN enables triangle mode 2;
//            without it mode 2 behaves as repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] start_freq,
    input  logic [11:0] stop_freq,
    input  logic [11:0] step,
    input  logic [15:0] dwell,
    input  logic [1:0]  mode,
    output logic [11:0] freq_ctrl,
    output logic        busy,
    output logic        done,
    output logic        wrap
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_freq, w_freq_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_dwell, w_dwell_nxt;
    logic [11:0] r_step, w_step_nxt;
    logic [11:0] r_origin, w_origin_nxt;
    logic [11:0] r_target, w_target_nxt;
    logic [1:0]  r_mode, w_mode_nxt;
    logic        r_up, w_up_nxt;
    logic        r_done, w_done_nxt;
    logic        r_wrap, w_wrap_nxt;

    // Step toward tgt at 13 bits; any overshoot or range escape clamps to tgt.
    function automatic logic [11:0] f_step(
        input logic [11:0] cur,
        input logic [11:0] inc,
        input logic [11:0] tgt,
        input logic        up
    );
        logic [12:0] sum;
        if (up) begin
            sum    = {1'b0, cur} + {1'b0, inc};
            f_step = (sum[12] || (sum[11:0] >= tgt)) ? tgt : sum[11:0];
        end else begin
            sum    = {1'b0, cur} - {1'b0, inc};
            f_step = (sum[12] || (sum[11:0] <= tgt)) ? tgt : sum[11:0];
        end
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_freq   <= 12'd0;
            r_cnt    <= 16'd0;
            r_dwell  <= 16'd0;
            r_step   <= 12'd0;
            r_origin <= 12'd0;
            r_target <= 12'd0;
            r_mode   <= 2'd0;
            r_up     <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_freq   <= w_freq_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dwell  <= w_dwell_nxt;
            r_step   <= w_step_nxt;
            r_origin <= w_origin_nxt;
            r_target <= w_target_nxt;
            r_mode   <= w_mode_nxt;
            r_up     <= w_up_nxt;
            r_done   <= w_done_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_freq_nxt   = r_freq;
        w_cnt_nxt    = r_cnt;
        w_dwell_nxt  = r_dwell;
        w_step_nxt   = r_step;
        w_origin_nxt = r_origin;
        w_target_nxt = r_target;
        w_mode_nxt   = r_mode;
        w_up_nxt     = r_up;
        w_done_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_SWEEP;
                    w_freq_nxt   = start_freq;
                    w_cnt_nxt    = 16'd0;
                    w_dwell_nxt  = dwell;
                    w_step_nxt   = (step == 12'd0) ? 12'd1 : step;
                    w_origin_nxt = start_freq;
                    w_target_nxt = stop_freq;
                    w_mode_nxt   = mode;
                    w_up_nxt     = (start_freq <= stop_freq);
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != r_dwell) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end else begin
                    w_cnt_nxt = 16'd0;
                    if (r_freq != r_target) begin
                        w_freq_nxt = f_step(r_freq, r_step, r_target, r_up);
`ifdef DDS_SWEEP_TRIANGLE_EN
                    end else if (r_mode == 2'd2) begin
                        // End point reached: swap origin and target, head back.
                        w_up_nxt     = ~r_up;
                        w_origin_nxt = r_target;
                        w_target_nxt = r_origin;
                        w_freq_nxt   = f_step(r_freq, r_step, r_origin, ~r_up);
                        w_wrap_nxt   = 1'b1;
                    end else if (r_mode == 2'd1) begin
                        w_freq_nxt = r_origin;
                        w_wrap_nxt = 1'b1;
`else
                    end else if ((r_mode == 2'd1) || (r_mode == 2'd2)) begin
                        w_freq_nxt = r_origin;
                        w_wrap_nxt = 1'b1;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign freq_ctrl = r_freq;
    assign busy      = (r_state == S_SWEEP);
    assign done      = r_done;
    assign wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Brief    : Directed self-checking bench for dds_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] start_freq;
    logic [11:0] stop_freq;
    logic [11:0] step;
    logic [15:0] dwell;
    logic [1:0]  mode;
    logic [11:0] freq_ctrl;
    logic        busy;
    logic        done;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    dds_sweep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .start_freq (start_freq),
        .stop_freq  (stop_freq),
        .step       (step),
        .dwell      (dwell),
        .mode       (mode),
        .freq_ctrl  (freq_ctrl),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [11:0] sf, input logic [11:0] sp,
                          input logic [11:0] st, input logic [15:0] dw,
                          input logic [1:0] md);
        start_freq = sf;
        stop_freq  = sp;
        step       = st;
        dwell      = dw;
        mode       = md;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    int exp_f [8];
    int exp_w [8];

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        start_freq = '0; stop_freq = '0; step = '0; dwell = '0; mode = '0;
        #23;
        chk("rst_freq", freq_ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        reset = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single sweep 100..130 step 10 dwell 3
        launch(100, 130, 10, 3, 0);
        for (int i = 0; i < 16; i++) begin
            chk("single_freq", freq_ctrl, 16'(100 + 10 * (i / 4)));
            chk("single_busy", busy, 1);
            chk("single_done", done, 0);
            tick();
        end
        chk("single_done_pulse", done, 1);
        chk("single_busy_end", busy, 0);
        chk("single_freq_end", freq_ctrl, 130);
        tick();
        chk("single_done_clr", done, 0);
        chk("single_freq_hold", freq_ctrl, 130);

        // Clamp ascending 0..25 step 10
        launch(0, 25, 10, 0, 0);
        exp_f = '{0, 10, 20, 25, 25, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            chk("clamp_up_freq", freq_ctrl, 16'(exp_f[i]));
            tick();
        end
        chk("clamp_up_done", done, 1);
        chk("clamp_up_freq_end", freq_ctrl, 25);

        // Descending 4095..4000 step 50, no wrap through 0
        launch(4095, 4000, 50, 0, 0);
        exp_f = '{4095, 4045, 4000, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            chk("desc_freq", freq_ctrl, 16'(exp_f[i]));
            tick();
        end
        chk("desc_done", done, 1);
        chk("desc_freq_end", freq_ctrl, 4000);

        // Repeat 10..30
        launch(10, 30, 10, 0, 1);
        exp_f = '{10, 20, 30, 10, 20, 30, 10, 20};
        exp_w = '{0, 0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            chk("rep_freq", freq_ctrl, 16'(exp_f[i]));
            chk("rep_wrap", wrap, 16'(exp_w[i]));
            chk("rep_done", done, 0);
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("rep_abort_busy", busy, 0);

        // Triangle (or repeat when triangle is compiled out)
        launch(10, 30, 10, 0, 2);
`ifdef DDS_SWEEP_TRIANGLE_EN
        exp_f = '{10, 20, 30, 20, 10, 20, 30, 20};
        exp_w = '{0, 0, 0, 1, 0, 1, 0, 1};
`else
        exp_f = '{10, 20, 30, 10, 20, 30, 10, 20};
        exp_w = '{0, 0, 0, 1, 0, 0, 1, 0};
`endif
        for (int i = 0; i < 8; i++) begin
            chk("tri_freq", freq_ctrl, 16'(exp_f[i]));
            chk("tri_wrap", wrap, 16'(exp_w[i]));
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("tri_abort_busy", busy, 0);

        // Abort with an ignored mid-sweep start and changed inputs
        launch(10, 30, 10, 0, 1);
        chk("abt_first", freq_ctrl, 10);
        start = 1'b1; start_freq = 999; step = 1;
        tick();
        start = 1'b0;
        chk("abt_ignored_start", freq_ctrl, 20);
        chk("abt_busy_before", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy", busy, 0);
        chk("abt_freq", freq_ctrl, 20);
        chk("abt_done", done, 0);
        tick();
        chk("abt_hold_freq", freq_ctrl, 20);
        chk("abt_hold_done", done, 0);
        chk("abt_hold_busy", busy, 0);

        // Asynchronous reset between edges while freq_ctrl = 110
        launch(100, 130, 10, 3, 0);
        repeat (4) tick();
        chk("rstmid_pre", freq_ctrl, 110);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_freq", freq_ctrl, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_wrap", wrap, 0);
        #3;
        reset = 1'b1;
        tick();
        tick();
        chk("rstmid_idle_busy", busy, 0);
        chk("rstmid_idle_freq", freq_ctrl, 0);

        // step = 0 advances by 1
        launch(5, 8, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("step0_freq", freq_ctrl, 16'(5 + i));
            tick();
        end
        chk("step0_done", done, 1);

        // start == stop, single mode, dwell 2
        launch(500, 500, 7, 2, 0);
        for (int i = 0; i < 3; i++) begin
            chk("eq_freq", freq_ctrl, 500);
            chk("eq_done", done, 0);
            chk("eq_busy", busy, 1);
            tick();
        end
        chk("eq_done_pulse", done, 1);
        chk("eq_busy_end", busy, 0);

        // New start accepted on the done cycle
        launch(7, 7, 1, 0, 0);
        chk("restart_freq", freq_ctrl, 7);
        chk("restart_busy", busy, 1);
        tick();
        chk("restart_done", done, 1);

        // start == stop in repeat mode: wrap every dwell+1 clocks
        launch(40, 40, 3, 1, 1);
        exp_w = '{0, 0, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            chk("eqrep_freq", freq_ctrl, 40);
            chk("eqrep_wrap", wrap, 16'(exp_w[i]));
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("eqrep_abort", busy, 0);

        // start and abort together in IDLE: sweep launches
        abort = 1'b1;
        launch(200, 210, 10, 0, 0);
        abort = 1'b0;
        chk("startabort_busy", busy, 1);
        chk("startabort_freq", freq_ctrl, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
